fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 69 ++++++
 tb/tb_fetch_queue.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer between fetch and decode.
// Flush discards all entries; reset has priority over everything.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       inValid,
  input  logic [WIDTH-1:0]           inProgramCounter,
  input  logic [WIDTH-1:0]           inInstruction,
  output logic                       inReady,
  output logic                       outValid,
  output logic [WIDTH-1:0]           outProgramCounter,
  output logic [WIDTH-1:0]           outInstruction,
  input  logic                       outReady,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] pc_mem  [DEPTH];
  logic [WIDTH-1:0] ins_mem [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          push;
  logic          pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign inReady = !full && !flush;
  assign outValid = !empty;
  assign push    = inValid && inReady;
  assign pop     = outValid && outReady;

  assign outProgramCounter = pc_mem[head];
  assign outInstruction    = ins_mem[head];

  // Entry storage; the write is gated by push, which already excludes flush.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      pc_mem[tail]  <= inProgramCounter;
      ins_mem[tail] <= inInstruction;
    end
  end

  // Pointers and occupancy; reset beats flush, flush beats push/pop.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_fetch_queue;

  localparam int D = 4;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset;
  logic         inValid;
  logic [W-1:0] inProgramCounter;
  logic [W-1:0] inInstruction;
  logic         inReady;
  logic         outValid;
  logic [W-1:0] outProgramCounter;
  logic [W-1:0] outInstruction;
  logic         outReady;
  logic         flush;
  logic [2:0]   count;
  logic         full;
  logic         empty;

  typedef struct {
    logic [W-1:0] pc;
    logic [W-1:0] ins;
  } ent_t;

  ent_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  fetch_queue #(.DEPTH(D), .WIDTH(W)) dut (
    .clock            (clock),
    .reset            (reset),
    .inValid          (inValid),
    .inProgramCounter (inProgramCounter),
    .inInstruction    (inInstruction),
    .inReady          (inReady),
    .outValid         (outValid),
    .outProgramCounter(outProgramCounter),
    .outInstruction   (outInstruction),
    .outReady         (outReady),
    .flush            (flush),
    .count            (count),
    .full             (full),
    .empty            (empty)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check before the edge, update model.
  task automatic step(input logic v, input logic [W-1:0] p,
                      input logic ordy, input logic fl,
                      input logic rst);
    logic [W-1:0] ins;
    logic exp_in;
    logic do_push;
    logic do_pop;
    ent_t e;
    ins = $urandom;
    @(negedge clock);
    inValid = v;
    inProgramCounter = p;
    inInstruction = ins;
    outReady = ordy;
    flush = fl;
    reset = rst;
    #1;
    exp_in = (q.size() != D) && !fl;
    chk("count", W'(count), W'(q.size()));
    chk("empty", W'(empty), W'(q.size() == 0));
    chk("full", W'(full), W'(q.size() == D));
    chk("outValid", W'(outValid), W'(q.size() != 0));
    chk("inReady", W'(inReady), W'(exp_in));
    if (q.size() != 0) begin
      chk("outPC", outProgramCounter, q[0].pc);
      chk("outIns", outInstruction, q[0].ins);
    end
    do_push = v && exp_in;
    do_pop = (q.size() != 0) && ordy;
    @(posedge clock);
    if (rst || fl) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        e.pc = p;
        e.ins = ins;
        q.push_back(e);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    inValid = 1'b0;
    inProgramCounter = '0;
    inInstruction = '0;
    outReady = 1'b0;
    flush = 1'b0;
    @(posedge clock);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h0, 1'b1, 1'b0, 1'b1);

    // Fill with decode stalled, then drain.
    for (int k = 0; k < 4; k++)
      step(1'b1, 32'(k * 4), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Streaming from empty.
    for (int k = 0; k < 8; k++)
      step(1'b1, 32'h100 + 32'(k * 4), 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Wrap: interleave 6 pushes and 6 pops.
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 32'h200 + 32'(k * 4), 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Flush with concurrent push and pop offered.
    for (int k = 0; k < 3; k++)
      step(1'b1, 32'h300 + 32'(k * 4), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h399, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Full with pop: pop proceeds, push blocked.
    for (int k = 0; k < 4; k++)
      step(1'b1, 32'h500 + 32'(k * 4), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h577, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Reset mid-stream.
    step(1'b1, 32'h600, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h604, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h608, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h60C, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Random traffic.
    for (int k = 0; k < 400; k++)
      step(1'($urandom_range(0, 3) != 0), $urandom,
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 79) == 0));
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
